// File: rtl/hazard_unit.sv
// hazard_unit -- pipeline control for the five-stage RISC-V datapath.
//
// Computes Execute-stage forwarding selects, detects load-use hazards,
// flushes wrong-path instructions on taken branches/jumps and freezes the
// pipeline while data memory has not accepted a Memory-stage access.
// Keeps stall/flush cycle counters and a sticky memory-timeout flag.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   Rs1D, Rs2D                 Decode source registers
//   Rs1E, Rs2E, RdE            Execute source/destination registers
//   RdM, RdW                   Memory/Writeback destination registers
//   RegWriteM, RegWriteW       Memory/Writeback register-write enables
//   ResultSrcE0                Execute instruction is a load
//   PCSrcE                     taken branch/jump in Execute
//   MemReqM, MemReadyM         Memory-stage access request / accept
//   ForwardAE, ForwardBE       10 = ALUResultM, 01 = ResultW, 00 = regfile
//   StallF/D/E/M               hold PC / F/D / D/E / E/M registers
//   FlushD/E/W                 bubble F/D / D/E / M/W registers
//   MemTimeout                 sticky: memory wait reached TIMEOUT cycles
//   StallCount, FlushCount     cycles with StallF / FlushE asserted
module hazard_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        ResultSrcE0,
  input  logic        PCSrcE,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic        MemTimeout,
  output logic [31:0] StallCount,
  output logic [15:0] FlushCount
);

  // Wait counter is at least 8 bits, wider if TIMEOUT needs it.
  localparam int CLOG = $clog2(TIMEOUT + 1);
  localparam int CW   = (CLOG > 8) ? CLOG : 8;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt_inc;
  logic          r_to;
  logic [31:0]   r_stall_cnt;
  logic [15:0]   r_flush_cnt;
  logic          w_lw_stall, w_mem_stall;

  // Forwarding: Memory-stage producer is younger, so it wins over Writeback.
  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;
  end

  assign w_lw_stall  = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign w_mem_stall = MemReqM && !MemReadyM;

  // Memory freeze dominates: Execute is held, so a branch or load-use in
  // the same cycle simply re-presents itself on the release cycle.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (w_mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      // Decode holds a wrong-path instruction, so its load-use is moot.
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (w_lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_mem_stall) w_next = S_WAIT;
      S_WAIT:  if (MemReadyM)   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_cnt_inc = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_to        <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_mem_stall) r_cnt <= '0;
      else if (r_state == S_WAIT)           r_cnt <= w_cnt_inc;
      // Set at the edge ending the TIMEOUT-th WAIT cycle.
      if (r_state == S_WAIT && w_cnt_inc >= CW'(TIMEOUT)) r_to <= 1'b1;
      r_stall_cnt <= r_stall_cnt + {31'd0, StallF};
      r_flush_cnt <= r_flush_cnt + {15'd0, FlushE};
    end
  end

  assign MemTimeout = r_to;
  assign StallCount = r_stall_cnt;
  assign FlushCount = r_flush_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit (TIMEOUT=4). Each vector drives one
// cycle of inputs; its expected outputs go onto a scoreboard queue and are
// popped and compared mid-cycle. Counter expectations come from a small
// model that tallies the expected StallF/FlushE of each cycle.
module tb_hazard_unit;

  logic        clk, reset;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic        MemTimeout;
  logic [31:0] StallCount;
  logic [15:0] FlushCount;

  hazard_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemTimeout(MemTimeout), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  localparam logic [6:0] C_NONE = 7'b0000_000;
  localparam logic [6:0] C_LW   = 7'b1100_010;
  localparam logic [6:0] C_BR   = 7'b0000_110;
  localparam logic [6:0] C_MEM  = 7'b1111_001;

  typedef struct {
    logic       rst;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwm, rww, ld, pc, req, rdy;
    logic [1:0] fa, fb;
    logic [6:0] ctl;
    logic       to;
  } vec_t;

  vec_t        tbl[$];
  vec_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_stall;
  logic [15:0] m_flush;

  function automatic vec_t z();
    vec_t v;
    v = '{default: '0};
    return v;
  endfunction

  function automatic vec_t mv(logic rst, logic req, logic rdy, logic [6:0] ctl, logic to);
    vec_t v;
    v = z();
    v.rst = rst; v.req = req; v.rdy = rdy; v.ctl = ctl; v.to = to;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %h expected %h", nm, n_vec, got, exp);
    end
  endtask

  task automatic apply(vec_t v);
    vec_t e;
    reset = v.rst;
    Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e; RdE = v.rde;
    RdM = v.rdm; RdW = v.rdw; RegWriteM = v.rwm; RegWriteW = v.rww;
    ResultSrcE0 = v.ld; PCSrcE = v.pc; MemReqM = v.req; MemReadyM = v.rdy;
    sb.push_back(v);
    #3;
    e = sb.pop_front();
    chk("fwd", {28'd0, ForwardAE, ForwardBE}, {28'd0, e.fa, e.fb});
    chk("ctl", {25'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW},
        {25'd0, e.ctl});
    chk("timeout", {31'd0, MemTimeout}, {31'd0, e.to});
    chk("stallcnt", StallCount, m_stall);
    chk("flushcnt", {16'd0, FlushCount}, {16'd0, m_flush});
    n_vec++;
    @(posedge clk);
    #1;
    if (e.rst) begin
      m_stall = '0;
      m_flush = '0;
    end else begin
      m_stall = m_stall + {31'd0, e.ctl[6]};
      m_flush = m_flush + {15'd0, e.ctl[1]};
    end
  endtask

  initial begin
    vec_t v;
    reset = 1'b1;
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM} = '0;
    m_stall = '0;
    m_flush = '0;
    repeat (2) @(posedge clk);
    #1;

    // ---- table: combinational function ----
    tbl.push_back(mv(1'b1, 1'b0, 1'b0, C_NONE, 1'b0));             // reset state
    v = z(); v.rdm = 5; v.rdw = 5; v.rs1e = 5; v.rwm = 1; v.rww = 1;
    v.fa = 2'b10; tbl.push_back(v);                               // M wins
    v.rwm = 0; v.fa = 2'b01; tbl.push_back(v);                    // W only
    v = z(); v.rwm = 1; v.rww = 1; tbl.push_back(v);              // x0 never
    v = z(); v.rdm = 3; v.rdw = 3; v.rs1e = 3; v.rs2e = 3; v.rwm = 1; v.rww = 1;
    v.fa = 2'b10; v.fb = 2'b10; tbl.push_back(v);
    v = z(); v.rdm = 4; v.rs1e = 4; v.rdw = 9; v.rs2e = 9; v.rwm = 1; v.rww = 1;
    v.fa = 2'b10; v.fb = 2'b01; tbl.push_back(v);
    v = z(); v.ld = 1; v.rde = 7; v.rs2d = 7; v.ctl = C_LW; tbl.push_back(v);
    v = z(); tbl.push_back(v);                                    // counts 1/1
    v = z(); v.ld = 1; tbl.push_back(v);                          // RdE=0
    v = z(); v.rde = 7; v.rs1d = 7; tbl.push_back(v);             // not a load
    v = z(); v.ld = 1; v.rde = 7; v.rs1d = 7; v.pc = 1; v.ctl = C_BR;
    tbl.push_back(v);                                             // lw suppressed
    v = z(); v.pc = 1; v.ctl = C_BR; tbl.push_back(v);
    v = z(); v.ld = 1; v.rde = 7; v.rs1d = 7; v.pc = 1; v.req = 1;
    v.rdm = 2; v.rs1e = 2; v.rwm = 1; v.fa = 2'b10; v.ctl = C_MEM;
    tbl.push_back(v);                                             // freeze wins
    v.rdy = 1; v.ctl = C_BR; tbl.push_back(v);                    // release
    v.pc = 0; v.req = 0; v.rdy = 0; v.ctl = C_LW; tbl.push_back(v);
    v = z(); v.req = 1; v.rdy = 1; tbl.push_back(v);              // ready at once
    v = z(); tbl.push_back(v);
    foreach (tbl[i]) apply(tbl[i]);

    // ---- 3-cycle wait, release, then back-to-back wait (counter restarts) ----
    repeat (3) apply(mv(1'b0, 1'b1, 1'b0, C_MEM, 1'b0));
    apply(mv(1'b0, 1'b1, 1'b1, C_NONE, 1'b0));
    repeat (3) apply(mv(1'b0, 1'b1, 1'b0, C_MEM, 1'b0));
    apply(mv(1'b0, 1'b1, 1'b1, C_NONE, 1'b0));
    apply(mv(1'b0, 1'b0, 1'b0, C_NONE, 1'b0));

    // ---- timeout: IDLE cycle + 4 WAIT cycles, flag visible after 4th ----
    repeat (5) apply(mv(1'b0, 1'b1, 1'b0, C_MEM, 1'b0));
    apply(mv(1'b0, 1'b1, 1'b0, C_MEM, 1'b1));
    apply(mv(1'b0, 1'b1, 1'b1, C_NONE, 1'b1));                    // sticky
    apply(mv(1'b0, 1'b0, 1'b0, C_NONE, 1'b1));

    // ---- reset while in WAIT ----
    apply(mv(1'b0, 1'b1, 1'b0, C_MEM, 1'b1));
    apply(mv(1'b1, 1'b1, 1'b0, C_MEM, 1'b1));                     // comb follows
    apply(mv(1'b0, 1'b0, 1'b0, C_NONE, 1'b0));                    // all cleared
    repeat (5) apply(mv(1'b0, 1'b1, 1'b0, C_MEM, 1'b0));          // fresh from IDLE
    apply(mv(1'b0, 1'b1, 1'b0, C_MEM, 1'b1));
    apply(mv(1'b0, 1'b1, 1'b1, C_NONE, 1'b1));
    apply(mv(1'b0, 1'b0, 1'b0, C_NONE, 1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
